// File: rtl/mux_4_arb.sv
// mux_4_arb: two one-entry channel buffers arbitrated onto a registered 4-bit 2:1 mux (a, b, en).
// Latency: a word offered in cycle n is shown with out_valid in cycle n+2; streams one word per cycle.
// Backpressure: out_ready=0 freezes SEND_x; x_ready = !x_full. Define MUX4_FIXED_PRIO_EN for A-wins ties.
module mux_4_arb (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] a_in,
  input  logic       a_valid,
  output logic       a_ready,
  input  logic [3:0] b_in,
  input  logic       b_valid,
  output logic       b_ready,
  output logic [3:0] a,
  output logic [3:0] b,
  output logic       en,
  output logic       out_valid,
  input  logic       out_ready
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEND_A = 2'd1,
    SEND_B = 2'd2
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [3:0] a_buf;
  logic [3:0] b_buf;
  logic       a_full;
  logic       b_full;
  logic       a_take;
  logic       b_take;
  logic       grant_a;
  logic       grant_b;
  logic       eval;

  assign a_ready   = !a_full;
  assign b_ready   = !b_full;
  assign a_take    = a_valid && a_ready;
  assign b_take    = b_valid && b_ready;
  assign out_valid = (state != IDLE);

`ifndef MUX4_FIXED_PRIO_EN
  // 1 when B won the most recent grant, so the next tie goes to A.
  logic last_grant_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_b <= 1'b1;
    end else if (grant_a) begin
      last_grant_b <= 1'b0;
    end else if (grant_b) begin
      last_grant_b <= 1'b1;
    end
  end
`endif

  // Grant decisions only look at the registered full flags.
  always_comb begin
    grant_a   = 1'b0;
    grant_b   = 1'b0;
    state_nxt = state;
    eval      = (state == IDLE) || out_ready;
    if (eval) begin
      if (a_full && b_full) begin
`ifdef MUX4_FIXED_PRIO_EN
        grant_a = 1'b1;
`else
        grant_a = last_grant_b;
        grant_b = !last_grant_b;
`endif
      end else begin
        grant_a = a_full;
        grant_b = b_full;
      end
      if (grant_a) begin
        state_nxt = SEND_A;
      end else if (grant_b) begin
        state_nxt = SEND_B;
      end else begin
        state_nxt = IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // A buffer can only be loaded while empty and only granted while full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_buf  <= 4'h0;
      a_full <= 1'b0;
      b_buf  <= 4'h0;
      b_full <= 1'b0;
    end else begin
      if (a_take) begin
        a_buf  <= a_in;
        a_full <= 1'b1;
      end else if (grant_a) begin
        a_full <= 1'b0;
      end
      if (b_take) begin
        b_buf  <= b_in;
        b_full <= 1'b1;
      end else if (grant_b) begin
        b_full <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a  <= 4'h0;
      b  <= 4'h0;
      en <= 1'b0;
    end else if (grant_a) begin
      a  <= a_buf;
      en <= 1'b0;
    end else if (grant_b) begin
      b  <= b_buf;
      en <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mux_4_arb.sv
// Bench for mux_4_arb: table of per-edge vectors, then reset-pulse and streaming sequences
// checked against a queue of expected {en, c} words.
module tb_mux_4_arb;

  logic       clk;
  logic       rst_n;
  logic [3:0] a_in;
  logic       a_valid;
  logic       a_ready;
  logic [3:0] b_in;
  logic       b_valid;
  logic       b_ready;
  logic [3:0] a;
  logic [3:0] b;
  logic       en;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] c;

  int n_vec = 0;
  int n_bad = 0;
  logic [4:0] sb[$];

  mux_4_arb dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .a_in     (a_in),
    .a_valid  (a_valid),
    .a_ready  (a_ready),
    .b_in     (b_in),
    .b_valid  (b_valid),
    .b_ready  (b_ready),
    .a        (a),
    .b        (b),
    .en       (en),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  // Downstream 2:1 mux output.
  assign c = en ? b : a;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       av;
    logic [3:0] ad;
    logic       bv;
    logic [3:0] bd;
    logic       ordy;
    logic       ov;
    logic [3:0] ea;
    logic [3:0] eb;
    logic       een;
    logic       ardy;
    logic       brdy;
  } vec_t;

  vec_t vecs[23];

  function automatic vec_t mk(input logic av, input logic [3:0] ad, input logic bv,
                              input logic [3:0] bd, input logic ordy, input logic ov,
                              input logic [3:0] ea, input logic [3:0] eb, input logic een,
                              input logic ardy, input logic brdy);
    vec_t v;
    v.av = av; v.ad = ad; v.bv = bv; v.bd = bd; v.ordy = ordy;
    v.ov = ov; v.ea = ea; v.eb = eb; v.een = een; v.ardy = ardy; v.brdy = brdy;
    return v;
  endfunction

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, required %b", nm, act, exp);
    end
  endtask

  task automatic chk4(input string nm, input logic [3:0] act, input logic [3:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  task automatic chki(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", nm, act, exp);
    end
  endtask

  // Called just after an edge: a word is consumed when out_valid && out_ready.
  task automatic observe(input string nm);
    logic [4:0] e;
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL %s_stale: got word en=%b c=%h, required no word", nm, en, c);
      end else begin
        e = sb.pop_front();
        chk1($sformatf("%s_en", nm), en, e[4]);
        chk4($sformatf("%s_c", nm), c, e[3:0]);
      end
    end
  endtask

  task automatic do_reset(input string nm);
    rst_n     = 1'b0;
    a_valid   = 1'b0;
    b_valid   = 1'b0;
    a_in      = 4'h0;
    b_in      = 4'h0;
    out_ready = 1'b1;
    #2;
    chk1($sformatf("%s_ov", nm), out_valid, 1'b0);
    chk1($sformatf("%s_en", nm), en, 1'b0);
    chk4($sformatf("%s_a", nm), a, 4'h0);
    chk4($sformatf("%s_b", nm), b, 4'h0);
    chk1($sformatf("%s_ardy", nm), a_ready, 1'b1);
    chk1($sformatf("%s_brdy", nm), b_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish before 200000");
    $fatal(1);
  end

  initial begin
    int nv;
    int first;
    int last;
    logic acc_a;
    logic acc_b;
    logic [3:0] a_src[$];
    logic [3:0] b_src[$];

    //              av    ad    bv    bd    ordy | ov    a     b     en    ardy  brdy
    vecs[0]  = mk(1'b1, 4'h3, 1'b1, 4'hC, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    vecs[1]  = mk(1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b1, 4'h3, 4'h0, 1'b0, 1'b1, 1'b0);
    vecs[2]  = mk(1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b1, 4'h3, 4'hC, 1'b1, 1'b1, 1'b1);
    vecs[3]  = mk(1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b0, 4'h3, 4'hC, 1'b1, 1'b1, 1'b1);
    vecs[4]  = mk(1'b1, 4'h5, 1'b0, 4'h0, 1'b1, 1'b0, 4'h3, 4'hC, 1'b1, 1'b0, 1'b1);
    vecs[5]  = mk(1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b1, 4'h5, 4'hC, 1'b0, 1'b1, 1'b1);
    vecs[6]  = mk(1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b0, 4'h5, 4'hC, 1'b0, 1'b1, 1'b1);
    // Tie after an A grant goes to B.
    vecs[7]  = mk(1'b1, 4'hD, 1'b1, 4'h2, 1'b1, 1'b0, 4'h5, 4'hC, 1'b0, 1'b0, 1'b0);
    vecs[8]  = mk(1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b1, 4'h5, 4'h2, 1'b1, 1'b0, 1'b1);
    vecs[9]  = mk(1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b1, 4'hD, 4'h2, 1'b0, 1'b1, 1'b1);
    vecs[10] = mk(1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b0, 4'hD, 4'h2, 1'b0, 1'b1, 1'b1);
    // SEND_B with b=9 stalled by out_ready=0; B word 1 waits in the buffer.
    vecs[11] = mk(1'b0, 4'h0, 1'b1, 4'h9, 1'b0, 1'b0, 4'hD, 4'h2, 1'b0, 1'b1, 1'b0);
    vecs[12] = mk(1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1, 4'hD, 4'h9, 1'b1, 1'b1, 1'b1);
    vecs[13] = mk(1'b0, 4'h0, 1'b1, 4'h1, 1'b0, 1'b1, 4'hD, 4'h9, 1'b1, 1'b1, 1'b0);
    vecs[14] = mk(1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1, 4'hD, 4'h9, 1'b1, 1'b1, 1'b0);
    vecs[15] = mk(1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1, 4'hD, 4'h9, 1'b1, 1'b1, 1'b0);
    vecs[16] = mk(1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1, 4'hD, 4'h9, 1'b1, 1'b1, 1'b0);
    vecs[17] = mk(1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1, 4'hD, 4'h9, 1'b1, 1'b1, 1'b0);
    vecs[18] = mk(1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b1, 4'hD, 4'h1, 1'b1, 1'b1, 1'b1);
    vecs[19] = mk(1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b0, 4'hD, 4'h1, 1'b1, 1'b1, 1'b1);
    // Park in SEND_A with both buffers full for the reset pulse.
    vecs[20] = mk(1'b1, 4'h7, 1'b1, 4'hE, 1'b1, 1'b0, 4'hD, 4'h1, 1'b1, 1'b0, 1'b0);
    vecs[21] = mk(1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1, 4'h7, 4'h1, 1'b0, 1'b1, 1'b0);
    vecs[22] = mk(1'b1, 4'h6, 1'b0, 4'h0, 1'b0, 1'b1, 4'h7, 4'h1, 1'b0, 1'b0, 1'b0);

    do_reset("rst0");

    for (int i = 0; i < 23; i++) begin
      a_valid   = vecs[i].av;
      a_in      = vecs[i].ad;
      b_valid   = vecs[i].bv;
      b_in      = vecs[i].bd;
      out_ready = vecs[i].ordy;
      @(posedge clk);
      #1;
      chk1($sformatf("r%0d_ov", i), out_valid, vecs[i].ov);
      chk4($sformatf("r%0d_a", i), a, vecs[i].ea);
      chk4($sformatf("r%0d_b", i), b, vecs[i].eb);
      chk1($sformatf("r%0d_en", i), en, vecs[i].een);
      chk1($sformatf("r%0d_ardy", i), a_ready, vecs[i].ardy);
      chk1($sformatf("r%0d_brdy", i), b_ready, vecs[i].brdy);
    end

    // Half-cycle reset pulse in SEND_A with both buffers full.
    a_valid   = 1'b0;
    b_valid   = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk1("pulse_ov", out_valid, 1'b0);
    chk1("pulse_en", en, 1'b0);
    chk4("pulse_a", a, 4'h0);
    chk4("pulse_b", b, 4'h0);
    chk1("pulse_ardy", a_ready, 1'b1);
    chk1("pulse_brdy", b_ready, 1'b1);
    #3;
    rst_n   = 1'b1;
    a_valid = 1'b1;
    a_in    = 4'h2;
    sb.push_back({1'b0, 4'h2});
    @(posedge clk);
    #1;
    chk1("post_rst_accept", a_ready, 1'b0);
    chk1("post_rst_ov0", out_valid, 1'b0);
    a_valid = 1'b0;
    nv = 0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      if (out_valid) nv++;
      observe("post_rst");
    end
    chki("post_rst_words", nv, 1);
    chki("post_rst_drained", sb.size(), 0);
    chk1("post_rst_brdy", b_ready, 1'b1);

    // Streaming with out_ready held high: expect A, B alternation at one word per cycle.
    do_reset("rst1");
    a_src = '{4'h1, 4'h2, 4'h3};
    b_src = '{4'h8, 4'h9, 4'hA};
    sb.push_back({1'b0, 4'h1});
    sb.push_back({1'b1, 4'h8});
    sb.push_back({1'b0, 4'h2});
    sb.push_back({1'b1, 4'h9});
    sb.push_back({1'b0, 4'h3});
    sb.push_back({1'b1, 4'hA});
    first = -1;
    last  = -1;
    for (int cyc = 0; cyc < 20 && sb.size() > 0; cyc++) begin
      a_valid = (a_src.size() > 0);
      b_valid = (b_src.size() > 0);
      if (a_valid) a_in = a_src[0];
      if (b_valid) b_in = b_src[0];
      acc_a = a_valid && a_ready;
      acc_b = b_valid && b_ready;
      @(posedge clk);
      #1;
      if (acc_a) void'(a_src.pop_front());
      if (acc_b) void'(b_src.pop_front());
      if (out_valid) begin
        if (first < 0) first = cyc;
        last = cyc;
      end
      observe("stream");
    end
    a_valid = 1'b0;
    b_valid = 1'b0;
    chki("stream_drained", sb.size(), 0);
    chki("stream_rate", last - first, 5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mux_4_arb.md
MUX_4_ARB -- requirements
Module: mux_4_arb

Interface
REQ-001 Parameters: none; data width is fixed at 4 bits to match the downstream 4-bit 2:1 mux.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 a_in  input  4  channel A data.
REQ-005 a_valid  input  1  channel A data offered.
REQ-006 a_ready  output  1  channel A buffer can accept.
REQ-007 b_in  input  4  channel B data.
REQ-008 b_valid  input  1  channel B data offered.
REQ-009 b_ready  output  1  channel B buffer can accept.
REQ-010 a  output  4  registered A word, to mux input a.
REQ-011 b  output  4  registered B word, to mux input b.
REQ-012 en  output  1  registered select, to mux en; 0 = A, 1 = B.
REQ-013 out_valid  output  1  mux output c carries a granted word.
REQ-014 out_ready  input  1  consumer takes c this cycle.

Function
REQ-015 Each channel SHALL have a one-entry holding buffer with a full flag; a_ready = !a_full and b_ready = !b_full, combinational from the flag only.
REQ-016 A channel transfer SHALL occur on a rising edge with valid && ready; the buffer loads the data and sets full.
REQ-017 The FSM SHALL have states IDLE, SEND_A and SEND_B; out_valid = 1 exactly in SEND_A/SEND_B.
REQ-018 Grant evaluation SHALL occur in IDLE, or in SEND_x when out_ready = 1; it uses the registered full flags, so a word accepted at edge t is grantable no earlier than edge t+1.
REQ-019 On grant to A: a <= A buffer, en <= 0, a_full cleared, next state SEND_A; on grant to B: b <= B buffer, en <= 1, b_full cleared, next state SEND_B; the non-granted data output holds its value.
REQ-020 If both channels are full at a grant point, the grant SHALL go to the channel opposite last_grant (round-robin); last_grant updates on every grant.
REQ-021 If no buffer is full at a grant point, the next state SHALL be IDLE and a, b, en hold.
REQ-022 In SEND_x with out_ready = 0, a, b, en, out_valid and the FSM SHALL hold.
REQ-023 With both inputs streaming and out_ready held at 1, throughput SHALL be one word per cycle once both buffers are primed, alternating A, B, A, B.
REQ-024 A buffer cleared by a grant SHALL raise its ready the following cycle; the block never accepts and grants the same channel on the same edge.
REQ-025 Latency SHALL be 2 cycles from input acceptance to out_valid with an idle block and free output.

Reset
REQ-026 rst_n low SHALL immediately clear a, b to 4'h0, en to 0, out_valid to 0, both full flags, FSM to IDLE and last_grant to B, so A wins the first tie.
REQ-027 Reset mid-operation SHALL discard buffered and in-flight words with no partial output; a_ready and b_ready go to 1 during reset.
REQ-028 After rst_n deasserts, the first acceptance SHALL occur on the first rising edge with rst_n high.

Configuration
REQ-029 Macro MUX4_FIXED_PRIO_EN: defined -> ties always grant A and last_grant is unused; undefined -> round-robin per REQ-020.

Verification
REQ-030 Reset then single A word 4'h5 with out_ready = 1 -> out_valid high 2 cycles after acceptance, a = 4'h5, en = 0, out_valid low the next cycle.
REQ-031 A = 4'h3 and B = 4'hC accepted on the same edge, out_ready = 1 -> outputs A (en = 0, c = 4'h3) then B (en = 1, c = 4'hC) on consecutive cycles; with MUX4_FIXED_PRIO_EN defined and A refilled continuously, B waits until A is not full.
REQ-032 out_ready held 0 for 5 cycles while SEND_B with b = 4'h9 -> a, b, en = 1 and out_valid stable all 5 cycles; b_ready rises after the grant and a second B word 4'h1 is buffered but not granted.
REQ-033 Continuous streaming A = 1,2,3 and B = 8,9,A with out_ready = 1 -> c sequence 1,8,2,9,3,A, one word per cycle.
REQ-034 rst_n pulsed low for half a cycle while in SEND_A with both buffers full -> out_valid, en, a, b drop to 0 immediately, both readies go to 1, and no stale word appears after release.
